// File: rtl/disp_sp_bundle_fetcher.sv
// disp_sp_bundle_fetcher: pops command bundles from the dispatch scratchpad queue head,
// fetches their words over the SP read port and presents them as one wide command.
// Optional status write-back of a completion word is enabled by defining DISP_SP_STATUS_WB_EN.
module disp_sp_bundle_fetcher #(
    parameter int NUM_WORDS      = 8,
    parameter int STATUS_REG_IDX = 31
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    iBundleValid,
    output logic                    oBundlePop,
    output logic [31:0]             oSPReadAddress,
    output logic                    oSPReadValid,
    input  logic [31:0]             iSPReadData,
    input  logic                    iSPReadAck,
    output logic [31:0]             oSPWriteAddress,
    output logic [31:0]             oSPWriteData,
    output logic                    oSPWriteValid,
    input  logic                    iSPWriteAck,
    output logic                    oCmdValid,
    input  logic                    iCmdReady,
    output logic [32*NUM_WORDS-1:0] oCmdWords,
    output logic [15:0]             oCmdIndex
);
    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

`ifdef DISP_SP_STATUS_WB_EN
    typedef enum logic [2:0] {IDLE, FETCH, PRESENT, WB, POP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, PRESENT, POP} state_t;
`endif

    state_t state, stateNext;
    logic [CW-1:0] wordCnt;
    logic lastWord;

    assign lastWord = wordCnt == CW'(NUM_WORDS - 1);

`ifndef DISP_SP_STATUS_WB_EN
    logic unusedWb;
    assign unusedWb = &{1'b0, iSPWriteAck, STATUS_REG_IDX[0]};
`endif

    // State register; reset drops any in-flight handshake and leaves the bundle at the head
    always_ff @(posedge iClock) begin
        state <= iReset ? IDLE : stateNext;
    end

    // Next-state and Moore outputs; every request is held until its ack
    always_comb begin
        stateNext       = state;
        oSPReadValid    = 1'b0;
        oSPReadAddress  = 32'd0;
        oSPWriteValid   = 1'b0;
        oSPWriteAddress = 32'd0;
        oSPWriteData    = 32'd0;
        oCmdValid       = 1'b0;
        oBundlePop      = 1'b0;
        case (state)
            IDLE: stateNext = iBundleValid ? FETCH : IDLE;
            FETCH: begin
                oSPReadValid   = 1'b1;
                oSPReadAddress = 32'(wordCnt);
                stateNext      = (iSPReadAck && lastWord) ? PRESENT : FETCH;
            end
`ifdef DISP_SP_STATUS_WB_EN
            PRESENT: begin
                oCmdValid = 1'b1;
                stateNext = iCmdReady ? WB : PRESENT;
            end
            WB: begin
                oSPWriteValid   = 1'b1;
                oSPWriteAddress = 32'(STATUS_REG_IDX);
                oSPWriteData    = {16'hC0DE, oCmdIndex};
                stateNext       = iSPWriteAck ? POP : WB;
            end
`else
            PRESENT: begin
                oCmdValid = 1'b1;
                stateNext = iCmdReady ? POP : PRESENT;
            end
`endif
            POP: begin
                oBundlePop = 1'b1;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Word counter, captured command words and bundle sequence number
    always_ff @(posedge iClock) begin
        if (iReset) begin
            wordCnt   <= '0;
            oCmdWords <= '0;
            oCmdIndex <= 16'd0;
        end else begin
            if (state == IDLE) wordCnt <= '0;
            if (state == FETCH && iSPReadAck) begin
                oCmdWords[32*int'(wordCnt) +: 32] <= iSPReadData;
                if (!lastWord) wordCnt <= wordCnt + 1'b1;
            end
            if (state == POP) oCmdIndex <= oCmdIndex + 16'd1;
        end
    end
endmodule

// File: tb/tb_disp_sp_bundle_fetcher.sv
// tb_disp_sp_bundle_fetcher: directed bench for the scratchpad bundle fetcher
module tb_disp_sp_bundle_fetcher;
    localparam int NW = 8;

    logic iClock = 1'b0;
    logic iReset = 1'b1;
    logic iBundleValid = 1'b0;
    logic iCmdReady = 1'b0;
    logic oBundlePop, oSPReadValid, iSPReadAck, oSPWriteValid, iSPWriteAck, oCmdValid;
    logic [31:0] oSPReadAddress, iSPReadData, oSPWriteAddress, oSPWriteData;
    logic [32*NW-1:0] oCmdWords;
    logic [15:0] oCmdIndex;

    int errors = 0;
    int checks = 0;
    int rdDelay = 0;
    int wrDelay = 0;
    int rdWait = 0;
    int wrWait = 0;
    int popCount = 0;
    int readCycles = 0;
    int wrCycles = 0;
    int holdErr = 0;
    logic prevReq = 1'b0;
    logic [31:0] prevAddr = 32'd0;
    logic [31:0] dataBase = 32'h100;

    disp_sp_bundle_fetcher #(.NUM_WORDS(NW), .STATUS_REG_IDX(31)) dut (
        .iClock(iClock), .iReset(iReset), .iBundleValid(iBundleValid), .oBundlePop(oBundlePop),
        .oSPReadAddress(oSPReadAddress), .oSPReadValid(oSPReadValid), .iSPReadData(iSPReadData),
        .iSPReadAck(iSPReadAck), .oSPWriteAddress(oSPWriteAddress), .oSPWriteData(oSPWriteData),
        .oSPWriteValid(oSPWriteValid), .iSPWriteAck(iSPWriteAck), .oCmdValid(oCmdValid),
        .iCmdReady(iCmdReady), .oCmdWords(oCmdWords), .oCmdIndex(oCmdIndex)
    );

    always #5 iClock = ~iClock;

    // Scratchpad model: acks after a programmable number of wait cycles, data = base + address
    assign iSPReadAck  = oSPReadValid && (rdWait == rdDelay);
    assign iSPReadData = dataBase + oSPReadAddress;
    assign iSPWriteAck = oSPWriteValid && (wrWait == wrDelay);

    always @(posedge iClock) begin
        rdWait <= (oSPReadValid && !iSPReadAck) ? rdWait + 1 : 0;
        wrWait <= (oSPWriteValid && !iSPWriteAck) ? wrWait + 1 : 0;
    end

    // Monitor: counts pops and request cycles, flags a read request changing before its ack
    always @(negedge iClock) begin
        if (oBundlePop) popCount++;
        if (oSPReadValid) readCycles++;
        if (oSPWriteValid) wrCycles++;
        if (!iReset && prevReq && (!oSPReadValid || oSPReadAddress != prevAddr)) holdErr++;
        prevReq  = oSPReadValid && !iSPReadAck && !iReset;
        prevAddr = oSPReadAddress;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] expWords(input logic [31:0] base);
        logic [255:0] w;
        w = '0;
        for (int i = 0; i < NW; i++) w[32*i +: 32] = base + 32'(i);
        return w;
    endfunction

    task automatic tick;
        @(posedge iClock);
        #1;
    endtask

    task automatic waitCmd(input bit dropValid, output int n);
        n = 0;
        while (!oCmdValid && n < 500) begin
            tick;
            n++;
            if (dropValid && n == 1) iBundleValid = 1'b0;
        end
        if (!oCmdValid) check("cmd_timeout", {255'd0, oCmdValid}, 256'd1);
    endtask

    // Accepts the presented command (iCmdReady already 1) and follows it through the pop
    task automatic acceptAndPop(input string tag, input bit dropAtPop);
        tick;
`ifdef DISP_SP_STATUS_WB_EN
        for (int m = 0; m < 50 && !oBundlePop; m++) tick;
`endif
        check({tag, "_pop"}, {255'd0, oBundlePop}, 256'd1);
        check({tag, "_noread_pop"}, {255'd0, oSPReadValid}, 256'd0);
        if (dropAtPop) iBundleValid = 1'b0;
        tick;
        check({tag, "_pop_once"}, {254'd0, oBundlePop, oSPReadValid}, 256'd0);
    endtask

    initial begin
        int n;
        int p0;
        int r0;
        int h0;
        int stableErr;
        logic [255:0] snap;

        // Reset state
        tick;
        tick;
        check("rst_valids", {252'd0, oCmdValid, oSPReadValid, oBundlePop, oSPWriteValid}, 256'd0);
        check("rst_index", {240'd0, oCmdIndex}, 256'd0);
        check("rst_words", oCmdWords, 256'd0);
        check("rst_addrs", {160'd0, oSPReadAddress, oSPWriteAddress, oSPWriteData}, 256'd0);
        iReset = 1'b0;
        tick;
        check("idle_no_req", {254'd0, oSPReadValid, oCmdValid}, 256'd0);

        // Single bundle, same-cycle ack
        dataBase = 32'h100;
        iCmdReady = 1'b1;
        iBundleValid = 1'b1;
        p0 = popCount;
        r0 = readCycles;
        waitCmd(1'b1, n);
        checkInt("t1_latency", n, 9);
        checkInt("t1_read_cycles", readCycles - r0, 8);
        check("t1_words", oCmdWords, expWords(32'h100));
        check("t1_index", {240'd0, oCmdIndex}, 256'd0);
        acceptAndPop("t1", 1'b0);
        check("t1_index_inc", {240'd0, oCmdIndex}, 256'd1);
        checkInt("t1_popcount", popCount - p0, 1);

        // Read ack delayed 3 cycles per word
        dataBase = 32'h200;
        rdDelay = 3;
        r0 = readCycles;
        h0 = holdErr;
        iBundleValid = 1'b1;
        waitCmd(1'b1, n);
        checkInt("t2_latency", n, 33);
        checkInt("t2_read_cycles", readCycles - r0, 32);
        checkInt("t2_hold", holdErr - h0, 0);
        check("t2_words", oCmdWords, expWords(32'h200));
        acceptAndPop("t2", 1'b0);
        check("t2_index", {240'd0, oCmdIndex}, 256'd2);
        rdDelay = 0;

        // Downstream back-pressure for 20 cycles
        dataBase = 32'h300;
        iCmdReady = 1'b0;
        iBundleValid = 1'b1;
        waitCmd(1'b1, n);
        checkInt("t3_latency", n, 9);
        snap = oCmdWords;
        p0 = popCount;
        r0 = readCycles;
        stableErr = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (!oCmdValid || oCmdWords !== snap || oBundlePop || oSPReadValid || oCmdIndex !== 16'd2)
                stableErr++;
        end
        checkInt("t3_stable", stableErr, 0);
        check("t3_words", snap, expWords(32'h300));
        checkInt("t3_no_pop", popCount - p0, 0);
        checkInt("t3_no_read", readCycles - r0, 0);
        iCmdReady = 1'b1;
        acceptAndPop("t3", 1'b0);
        check("t3_index", {240'd0, oCmdIndex}, 256'd3);

        // Reset clears the sequence number, then three bundles back to back
        iReset = 1'b1;
        tick;
        check("t4_rst_index", {240'd0, oCmdIndex}, 256'd0);
        iReset = 1'b0;
        dataBase = 32'h400;
        iBundleValid = 1'b1;
        p0 = popCount;
        for (int k = 0; k < 3; k++) begin
            waitCmd(1'b0, n);
            checkInt("t4_seq_index", int'(oCmdIndex), k);
            acceptAndPop("t4", k == 2);
        end
        repeat (5) tick;
        checkInt("t4_popcount", popCount - p0, 3);
        check("t4_idle", {254'd0, oSPReadValid, oCmdValid}, 256'd0);

        // Reset in the middle of a fetch
        dataBase = 32'h500;
        iBundleValid = 1'b1;
        tick;
        repeat (4) tick;
        check("t5_addr_mid", {224'd0, oSPReadAddress}, 256'd4);
        p0 = popCount;
        iReset = 1'b1;
        tick;
        check("t5_rst_outs", {252'd0, oCmdValid, oSPReadValid, oBundlePop, oSPWriteValid}, 256'd0);
        iReset = 1'b0;
        tick;
        check("t5_refetch", {223'd0, oSPReadValid, oSPReadAddress}, {223'd0, 1'b1, 32'd0});
        iBundleValid = 1'b0;
        waitCmd(1'b0, n);
        check("t5_words", oCmdWords, expWords(32'h500));
        check("t5_index", {240'd0, oCmdIndex}, 256'd0);
        acceptAndPop("t5", 1'b0);
        checkInt("t5_popcount", popCount - p0, 1);

`ifdef DISP_SP_STATUS_WB_EN
        // Status write-back with the ack delayed 2 cycles, at sequence number 5
        iBundleValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitCmd(1'b0, n);
            acceptAndPop("t6_pre", k == 3);
        end
        check("t6_index", {240'd0, oCmdIndex}, 256'd5);
        wrDelay = 2;
        r0 = wrCycles;
        p0 = popCount;
        iBundleValid = 1'b1;
        waitCmd(1'b1, n);
        tick;
        for (int i = 0; i < 3; i++) begin
            check("t6_write", {190'd0, oSPWriteValid, oBundlePop, oSPWriteAddress, oSPWriteData},
                  {190'd0, 1'b1, 1'b0, 32'd31, 32'hC0DE0005});
            tick;
        end
        check("t6_pop_after_ack", {254'd0, oBundlePop, oSPWriteValid}, {254'd0, 2'b10});
        tick;
        checkInt("t6_write_cycles", wrCycles - r0, 3);
        checkInt("t6_popcount", popCount - p0, 1);
        wrDelay = 0;
`else
        // Write port is unused without the status feature
        checkInt("t6_no_write", wrCycles, 0);
        check("t6_write_outs", {223'd0, oSPWriteValid, oSPWriteAddress}, 256'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/disp_sp_bundle_fetcher.md
Name: disp_sp_bundle_fetcher

Overview:
Sequencer for the pop side of the dispatch scratchpad queue.
- When a command bundle is at the queue head, fetches words 0..NUM_WORDS-1 of that bundle through the scratchpad SP read port (valid/ack handshake).
- Presents the fetched words as one wide command to the downstream dispatcher, then pops the bundle.
- Is the only master of the SP read, SP write and pop-ready signals.

Parameters:
- NUM_WORDS, 8: words fetched per bundle; legal range 1..32.
- STATUS_REG_IDX, 31: register index that receives the completion word (optional feature only); legal range 0..31.

Ports:
- iClock  in  1  clock
- iReset  in  1  reset
- iBundleValid  in  1  head bundle present (scratchpad pop-valid)
- oBundlePop  out  1  pop-ready to scratchpad; one-cycle pulse
- oSPReadAddress  out  32  word index, zero-extended
- oSPReadValid  out  1  read request
- iSPReadData  in  32  read data
- iSPReadAck  in  1  read complete; iSPReadData valid this cycle
- oSPWriteAddress  out  32  write word index
- oSPWriteData  out  32  write data
- oSPWriteValid  out  1  write request
- iSPWriteAck  in  1  write complete
- oCmdValid  out  1  command available
- iCmdReady  in  1  downstream accepts command
- oCmdWords  out  32*NUM_WORDS  fetched words; word i at bits [32i+31:32i]
- oCmdIndex  out  16  sequence number of the presented bundle

Behaviour:
- Reset is iReset, synchronous, active-high; clock is iClock.
- Reset values:
  - state IDLE; word counter 0; oCmdIndex 0; oCmdWords 0.
  - All valid outputs, oBundlePop and oCmdValid are 0.
  - oSPReadAddress, oSPWriteAddress and oSPWriteData are 0.
- Reset mid-operation abandons any outstanding read or write and any presented command. No pop is issued. The bundle stays at the head and is refetched after reset.
- State machine:
  - IDLE: if iBundleValid, go to FETCH with word counter = 0.
  - FETCH:
    - oSPReadValid = 1 and oSPReadAddress = word counter; both held until iSPReadAck.
    - On ack, capture iSPReadData into word[counter].
    - If counter == NUM_WORDS-1, go to PRESENT. Otherwise counter+1, and the next request starts in the following cycle.
    - Ack arriving in the same cycle that valid is first raised is legal; the word is captured that cycle.
  - PRESENT:
    - oCmdValid = 1; oCmdWords and oCmdIndex held stable.
    - On iCmdReady: go to WB if the feature is enabled, else to POP.
  - WB (optional feature only): see Optional Feature.
  - POP:
    - oBundlePop = 1 for exactly one cycle.
    - oCmdIndex increments, wrapping 0xFFFF->0.
    - Next state IDLE.
- IDLE is entered the cycle after the pop edge, so the scratchpad count has already been updated. No double pop is possible.
- Timing:
  - Minimum latency from iBundleValid rising to oCmdValid is NUM_WORDS*1 + 1 cycles, with ack returned in the same cycle.
  - Reads are strictly sequential: one outstanding at a time, never pipelined.
- iBundleValid is ignored outside IDLE.
- iSPReadAck outside FETCH and iSPWriteAck outside WB are ignored.
- oSPWriteValid is constant 0 when the feature is disabled.
- oCmdValid never drops without iCmdReady, except on reset.

Optional Feature:
- Macro: DISP_SP_STATUS_WB_EN.
- Enabled:
  - After the command is accepted in PRESENT, the FSM enters WB.
  - In WB: oSPWriteValid = 1, oSPWriteAddress = STATUS_REG_IDX, oSPWriteData = {16'hC0DE, oCmdIndex}. All held until iSPWriteAck.
  - On iSPWriteAck, go to POP.
  - Firmware can inspect the bundle slot to confirm dispatch.
- Disabled:
  - WB state, write logic and STATUS_REG_IDX usage are compiled out.
  - PRESENT goes directly to POP.
  - The write outputs are tied to 0.

Test Plan:
- Single bundle, NUM_WORDS=8, ack same cycle, data = 0x100+index, iCmdReady=1.
  Expected: oCmdWords word i = 0x100+i; oCmdValid high in the 9th cycle after iBundleValid; one oBundlePop pulse; oCmdIndex 0->1.
- Read ack delayed 3 cycles per word.
  Expected: oSPReadValid and oSPReadAddress held stable across each wait; total fetch = 32 cycles; words correct.
- iCmdReady held low 20 cycles after oCmdValid.
  Expected: oCmdValid and oCmdWords stable; no pop and no new reads until ready; pop the cycle after acceptance.
- iBundleValid held high, 3 bundles back-to-back.
  Expected: exactly 3 pops; oCmdIndex sequence 0,1,2; no reads issued between POP and IDLE.
- iReset asserted in FETCH after 4 of 8 words.
  Expected: next cycle all valids 0, no pop; after release with iBundleValid=1, fetch restarts at address 0.
- DISP_SP_STATUS_WB_EN defined, oCmdIndex=5, write ack delayed 2 cycles.
  Expected: write to address 31 with data 0xC0DE0005 held 3 cycles; pop only after ack.
